// File: rtl/uart_watch_pkg.sv
// Shared definitions for the UART watch path: datapath widths and the
// ASCII command bytes recognised by the decoder.
package uart_watch_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FIFO_ADDR_W = 4;

    localparam logic [7:0] CMD_R_UP = 8'h52;
    localparam logic [7:0] CMD_R_LO = 8'h72;
    localparam logic [7:0] CMD_C_UP = 8'h43;
    localparam logic [7:0] CMD_C_LO = 8'h63;
    localparam logic [7:0] CMD_H_UP = 8'h48;
    localparam logic [7:0] CMD_H_LO = 8'h68;
    localparam logic [7:0] CMD_M_UP = 8'h4D;
    localparam logic [7:0] CMD_M_LO = 8'h6D;
    localparam logic [7:0] CMD_S_UP = 8'h53;
    localparam logic [7:0] CMD_S_LO = 8'h73;

endpackage

// File: rtl/fifo_regfile.sv
// Storage for the receive FIFO: synchronous write, asynchronous read.
// The array is deliberately left without reset.
module fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the command
// decoder. Define UART_RX_FIFO_ERR_EN to add sticky overflow/underflow flags.
module uart_rx_fifo
    import uart_watch_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
`ifdef UART_RX_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            rd_accept;
    logic            wr_accept;

    // Extra MSB on each pointer separates full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

`ifdef UART_RX_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en && full && !rd_accept);
        underflow_d = underflow_q || (rd_en && empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte queue models the FIFO contents
// and every popped byte is compared against the DUT head.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef UART_RX_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
    logic       m_ovf;
    logic       m_unf;
`endif

    int checks;
    int errors;
    logic [7:0] sb [$];

    uart_rx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
`ifdef UART_RX_FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".empty"}, {31'b0, empty}, {31'b0, (sb.size() == 0)});
        chk({tag, ".full"},  {31'b0, full},  {31'b0, (sb.size() == 16)});
        chk({tag, ".count"}, {27'b0, count}, sb.size());
        if (sb.size() != 0) begin
            chk({tag, ".head"}, {24'b0, rd_data}, {24'b0, sb[0]});
        end
`ifdef UART_RX_FIFO_ERR_EN
        chk({tag, ".overflow"},  {31'b0, overflow},  {31'b0, m_ovf});
        chk({tag, ".underflow"}, {31'b0, underflow}, {31'b0, m_unf});
`endif
    endtask

    // One clock of stimulus; the popped byte is checked while rd_en is high.
    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        logic       rd_acc;
        logic       wr_acc;
        logic [7:0] exp_b;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        #1;
        rd_acc = re && (sb.size() != 0);
        wr_acc = we && ((sb.size() != 16) || rd_acc);
`ifdef UART_RX_FIFO_ERR_EN
        if (we && (sb.size() == 16) && !rd_acc) m_ovf = 1'b1;
        if (re && (sb.size() == 0)) m_unf = 1'b1;
`endif
        if (rd_acc) begin
            exp_b = sb.pop_front();
            chk("rd_data", {24'b0, rd_data}, {24'b0, exp_b});
        end
        if (wr_acc) sb.push_back(wd);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
`ifdef UART_RX_FIFO_ERR_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and read-while-empty
        chk_flags("reset");
        step(1'b0, 8'h00, 1'b1);
        chk_flags("rd_empty");

        // Single write then pop
        step(1'b1, 8'h52, 1'b0);
        chk_flags("wr1");
        step(1'b0, 8'h00, 1'b1);
        chk_flags("rd1");

        // Fill, drop when full, drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        chk_flags("fill16");
        step(1'b1, 8'hAA, 1'b0);
        chk_flags("drop17");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        chk_flags("drain16");

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h63, 1'b1);
        chk_flags("full_rw");
        chk("full_rw.head01", {24'b0, rd_data}, 32'h01);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        chk("last_is_63", {24'b0, rd_data}, 32'h63);
        step(1'b0, 8'h00, 1'b1);
        chk_flags("drain_rw");

        // Empty with simultaneous read and write
        step(1'b1, 8'h48, 1'b1);
        chk_flags("empty_rw");
        chk("empty_rw.head48", {24'b0, rd_data}, 32'h48);

        // Partially filled read+write plus a mixed random burst
        step(1'b1, 8'h4D, 1'b0);
        step(1'b1, 8'h53, 1'b1);
        chk_flags("part_rw");
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            chk_flags("rand");
        end

        // Asynchronous reset mid-burst
        while (sb.size() != 0) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        chk_flags("pre_reset");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
`ifdef UART_RX_FIFO_ERR_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        chk("async_reset.empty", {31'b0, empty}, 32'h1);
        chk("async_reset.count", {27'b0, count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk_flags("post_reset");
        step(1'b1, 8'h73, 1'b0);
        chk_flags("restart_wr");
        chk("restart.head73", {24'b0, rd_data}, 32'h73);
        step(1'b0, 8'h00, 1'b1);
        chk_flags("restart_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
